// File: rtl/bank_write_scheduler_if.sv
// Reference-word stream from the external fetch unit into the bank write
// scheduler: valid/ready handshake with one 8-pixel word per transfer.
interface bank_write_scheduler_if #(
    parameter int DW = 64
) ();
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;

    // Fetch unit side: offers words and watches ready.
    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    // Scheduler side: consumes words and drives ready.
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/bank_write_scheduler.sv
// Write-side sequencer for the reference-window bank array. Each accepted word
// is steered to one bank: BURST_LEN words per bank, banks in rotation, ROUNDS
// rotations per window fill. The write address tracks each bank's internal
// write counter so both stay aligned across the fill.
module bank_write_scheduler #(
    parameter int NUM_BANKS = 4,
    parameter int BURST_LEN = 24,
    parameter int ROUNDS    = 4,
    parameter int DW        = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    bank_write_scheduler_if.slave in_if,
    output logic                 beg_en,
    output logic [NUM_BANKS-1:0] bank_sel,
    output logic [DW-1:0]        ref_out,
    output logic [6:0]           wr_addr,
    output logic [2:0]           bank_idx,
    output logic                 busy,
    output logic                 fill_done,
    output logic                 window_valid
);

    localparam int WCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int RCW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [WCW-1:0] word_cnt;
    logic [RCW-1:0] round_cnt;
    logic           accept;
    logic           last_word;
    logic           start_fill;

    assign accept     = in_if.in_valid && in_if.in_ready;
    assign start_fill = (state == IDLE) && start;
    assign last_word  = (round_cnt == RCW'(ROUNDS - 1))
                     && (bank_idx == 3'(NUM_BANKS - 1))
                     && (word_cnt == WCW'(BURST_LEN - 1));

    // State register.
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and state-derived outputs.
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        next_state     = state;
        in_if.in_ready = 1'b0;
        busy           = 1'b0;
        fill_done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                in_if.in_ready = 1'b1;
                busy           = 1'b1;
                if (accept && last_word) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                fill_done  = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Word / bank / round counters; only accepted words advance them.
    always_ff @(posedge clk) begin
        if (rst || start_fill) begin
            word_cnt  <= '0;
            bank_idx  <= '0;
            round_cnt <= '0;
        end else if (accept) begin
            if (word_cnt == WCW'(BURST_LEN - 1)) begin
                word_cnt <= '0;
                if (bank_idx == 3'(NUM_BANKS - 1)) begin
                    bank_idx <= '0;
                    if (round_cnt == RCW'(ROUNDS - 1)) begin
                        round_cnt <= '0;
                    end else begin
                        round_cnt <= round_cnt + RCW'(1);
                    end
                end else begin
                    bank_idx <= bank_idx + 3'd1;
                end
            end else begin
                word_cnt <= word_cnt + WCW'(1);
            end
        end
    end

    // Registered bank write port: strobe and select pulse per accepted word,
    // data and address hold across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            beg_en   <= 1'b0;
            bank_sel <= '0;
            ref_out  <= '0;
            wr_addr  <= '0;
        end else begin
            beg_en   <= accept;
            bank_sel <= accept ? (NUM_BANKS'(1) << bank_idx) : '0;
            if (accept) begin
                ref_out <= in_if.in_data;
                wr_addr <= 7'(int'(round_cnt) * BURST_LEN + int'(word_cnt));
            end
        end
    end

    // Window-loaded flag: set after the DONE cycle, cleared by an accepted start.
    always_ff @(posedge clk) begin
        if (rst || start_fill) begin
            window_valid <= 1'b0;
        end else if (state == DONE) begin
            window_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bank_write_scheduler.sv
// Self-checking bench for bank_write_scheduler: directed fills with a
// scoreboard of expected bank writes and a 4-bank memory model.
module tb_bank_write_scheduler;

    localparam int NB    = 4;
    localparam int BL    = 24;
    localparam int RN    = 4;
    localparam int DW    = 64;
    localparam int DEPTH = BL * RN;
    localparam int TOTAL = NB * BL * RN;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          beg_en;
    logic [NB-1:0] bank_sel;
    logic [DW-1:0] ref_out;
    logic [6:0]    wr_addr;
    logic [2:0]    bank_idx;
    logic          busy;
    logic          fill_done;
    logic          window_valid;

    always #5 clk = ~clk;

    bank_write_scheduler_if #(.DW(DW)) in_if ();

    bank_write_scheduler #(
        .NUM_BANKS (NB),
        .BURST_LEN (BL),
        .ROUNDS    (RN),
        .DW        (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_if        (in_if),
        .beg_en       (beg_en),
        .bank_sel     (bank_sel),
        .ref_out      (ref_out),
        .wr_addr      (wr_addr),
        .bank_idx     (bank_idx),
        .busy         (busy),
        .fill_done    (fill_done),
        .window_valid (window_valid)
    );

    typedef struct {
        int            beat;
        logic [NB-1:0] sel;
        logic [6:0]    addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] mem [NB][DEPTH];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            beat;
    int            done_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected bank write for a given beat index of a fill.
    function automatic exp_t model(input int b);
        exp_t e;
        int   bank;
        int   rnd;
        int   w;
        bank   = (b / BL) % NB;
        rnd    = b / (BL * NB);
        w      = b % BL;
        e.beat = b;
        e.sel  = NB'(1) << bank;
        e.addr = 7'(rnd * BL + w);
        e.data = DW'(b);
        return e;
    endfunction

    // Compare the bank write port against the scoreboard at a negedge.
    task automatic observe();
        exp_t e;
        if (beg_en === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("bank_sel", 64'(bank_sel), 64'(e.sel));
                check("wr_addr", 64'(wr_addr), 64'(e.addr));
                check("ref_out", ref_out, e.data);
                check("fill_done_on_strobe", 64'(fill_done), 64'(e.beat == TOTAL - 1));
                if (e.beat == 0) begin
                    check("beat0_sel", 64'(bank_sel), 64'b0001);
                    check("beat0_addr", 64'(wr_addr), 64'd0);
                end
                if (e.beat == 24) begin
                    check("beat24_sel", 64'(bank_sel), 64'b0010);
                    check("beat24_addr", 64'(wr_addr), 64'd0);
                end
                if (e.beat == 96) begin
                    check("beat96_sel", 64'(bank_sel), 64'b0001);
                    check("beat96_addr", 64'(wr_addr), 64'd24);
                end
                if (e.beat == 383) begin
                    check("beat383_sel", 64'(bank_sel), 64'b1000);
                    check("beat383_addr", 64'(wr_addr), 64'd95);
                end
                for (int k = 0; k < NB; k++) begin
                    if (bank_sel[k] === 1'b1 && int'(wr_addr) < DEPTH) begin
                        mem[k][int'(wr_addr)] = ref_out;
                    end
                end
            end
        end else begin
            check("bubble_sel", 64'(bank_sel), 64'd0);
            check("bubble_fill_done", 64'(fill_done), 64'd0);
        end
        if (fill_done === 1'b1) begin
            done_cnt++;
        end
    endtask

    // One cycle: check outputs, then drive inputs and record any accept.
    task automatic step(input logic v, input logic s);
        @(negedge clk);
        observe();
        in_if.in_valid = v;
        in_if.in_data  = v ? DW'(beat) : {$urandom, $urandom};
        start          = s;
        if (v && in_if.in_ready === 1'b1) begin
            sb.push_back(model(beat));
            beat++;
        end
    endtask

    // Full window fill; pct = bubble percentage, start_beat = beat at which a
    // stray start is pulsed, abort_beat = beat at which rst is asserted.
    task automatic run_fill(input int pct, input int start_beat, input int abort_beat);
        int budget;
        beat     = 0;
        done_cnt = 0;
        budget   = 0;
        for (int k = 0; k < NB; k++) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem[k][a] = 'x;
            end
        end
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check("window_valid_after_start", 64'(window_valid), 64'd0);
        check("busy_after_start", 64'(busy), 64'd1);
        while (beat < TOTAL && budget < 4000) begin
            if (beat == abort_beat) begin
                @(negedge clk);
                observe();
                rst            = 1'b1;
                in_if.in_valid = 1'b0;
                start          = 1'b0;
                @(negedge clk);
                check("rst_beg_en", 64'(beg_en), 64'd0);
                check("rst_bank_sel", 64'(bank_sel), 64'd0);
                check("rst_ref_out", ref_out, 64'd0);
                check("rst_wr_addr", 64'(wr_addr), 64'd0);
                check("rst_bank_idx", 64'(bank_idx), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_in_ready", 64'(in_if.in_ready), 64'd0);
                check("rst_fill_done", 64'(fill_done), 64'd0);
                check("rst_window_valid", 64'(window_valid), 64'd0);
                check("rst_sb_drained", 64'(sb.size()), 64'd0);
                sb.delete();
                rst = 1'b0;
                return;
            end
            step(($urandom_range(99) >= pct), (beat == start_beat));
            budget++;
        end
        check("fill_within_budget", 64'(budget < 4000), 64'd1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("done_window_valid", 64'(window_valid), 64'd1);
        check("done_busy", 64'(busy), 64'd0);
        check("done_in_ready", 64'(in_if.in_ready), 64'd0);
        check("fill_done_pulses", 64'(done_cnt), 64'd1);
        check("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    // Every bank address must hold the beat that the fill order maps onto it.
    task automatic check_mem();
        for (int k = 0; k < NB; k++) begin
            for (int a = 0; a < DEPTH; a++) begin
                check($sformatf("bank%0d_addr%0d", k, a), mem[k][a],
                      64'((a / BL) * BL * NB + k * BL + a % BL));
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        in_if.in_valid = 1'b0;
        in_if.in_data  = '0;
        beat           = 0;
        done_cnt       = 0;
        repeat (2) @(negedge clk);
        check("reset_beg_en", 64'(beg_en), 64'd0);
        check("reset_bank_sel", 64'(bank_sel), 64'd0);
        check("reset_ref_out", ref_out, 64'd0);
        check("reset_wr_addr", 64'(wr_addr), 64'd0);
        check("reset_window_valid", 64'(window_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        rst = 1'b0;

        // Idle with valid data offered and no start: nothing is accepted.
        repeat (10) begin
            step(1'b1, 1'b0);
            check("idle_in_ready", 64'(in_if.in_ready), 64'd0);
            check("idle_window_valid", 64'(window_valid), 64'd0);
        end
        step(1'b0, 1'b0);
        check("idle_sb_empty", 64'(sb.size()), 64'd0);

        // Back-to-back fill.
        run_fill(0, -1, -1);
        check_mem();

        // Bubbled fill; its start also drops window_valid from the first fill.
        run_fill(50, -1, -1);
        check_mem();

        // Stray start mid-fill is ignored.
        run_fill(0, 50, -1);
        check_mem();

        // Reset mid-fill, then a clean restart from bank 0, address 0.
        run_fill(0, -1, 200);
        run_fill(0, -1, -1);
        check_mem();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
